// File: rtl/lpc_io_write_target.sv
// LPC I/O write target: decodes host I/O write cycles addressed to a 32-byte
// window, answers with a ready SYNC and commits the byte into the register bank.
module lpc_io_write_target #(
    parameter logic [15:0] BASE_ADDR  = 16'h0800,
    parameter logic [7:0]  HW_VERSION = 8'h01
) (
    input  logic             LpcClock,
    input  logic             PciReset,
    input  logic             LpcFrame_n,
    input  logic [3:0]       LadIn,
    output logic [3:0]       LadOut,
    output logic             LadOe,
    output logic [31:0][7:0] DataReg,
    output logic             WrStrobe,
    output logic [7:0]       WrAddr,
    output logic [7:0]       WrData
);

    localparam logic [3:0] LAD_START  = 4'h0;
    localparam logic [3:0] CYC_IO_WR  = 4'b0010;
    localparam logic [3:0] LAD_SYNC   = 4'h0;
    localparam logic [3:0] LAD_IDLE   = 4'hF;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_START = 4'd1,
        ST_ADDR  = 4'd2,
        ST_DATA  = 4'd3,
        ST_HTAR0 = 4'd4,
        ST_HTAR1 = 4'd5,
        ST_SYNC  = 4'd6,
        ST_TTAR  = 4'd7,
        ST_SKIP  = 4'd8
    } state_e;

    state_e            state_q;
    logic [1:0]        cnt_q;
    logic [15:0]       addr_q;
    logic [7:0]        data_q;
    logic [3:0]        lad_out_q;
    logic              lad_oe_q;
    logic              wr_stb_q;
    logic [4:0]        wr_addr_q;
    logic [7:0]        wr_data_q;
    logic [31:0][7:0]  bank_q;

    // Cycle decoder, bus drive and register bank, all in one registered FSM.
    always_ff @(posedge LpcClock or negedge PciReset) begin
        if (!PciReset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 2'd0;
            addr_q    <= 16'h0000;
            data_q    <= 8'h00;
            lad_out_q <= LAD_IDLE;
            lad_oe_q  <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= 5'd0;
            wr_data_q <= 8'h00;
            bank_q    <= {{31{8'h00}}, HW_VERSION};
        end else begin
            wr_stb_q <= 1'b0;
            if (!LpcFrame_n) begin
                // LFRAME# low always restarts framing; any pending write is dropped.
                lad_oe_q  <= 1'b0;
                lad_out_q <= LAD_IDLE;
                cnt_q     <= 2'd0;
                state_q   <= (LadIn == LAD_START) ? ST_START : ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE, ST_SKIP: begin
                        state_q <= state_q;
                    end
                    ST_START: begin
                        cnt_q   <= 2'd0;
                        state_q <= (LadIn == CYC_IO_WR) ? ST_ADDR : ST_SKIP;
                    end
                    ST_ADDR: begin
                        addr_q <= {addr_q[11:0], LadIn};
                        if (cnt_q == 2'd3) begin
                            cnt_q   <= 2'd0;
                            state_q <= ST_DATA;
                        end else begin
                            cnt_q <= cnt_q + 2'd1;
                        end
                    end
                    ST_DATA: begin
                        if (cnt_q[0] == 1'b0) begin
                            data_q[3:0] <= LadIn;
                            cnt_q       <= 2'd1;
                        end else begin
                            data_q[7:4] <= LadIn;
                            cnt_q       <= 2'd0;
                            state_q     <= (addr_q[15:5] == BASE_ADDR[15:5]) ? ST_HTAR0 : ST_SKIP;
                        end
                    end
                    ST_HTAR0: begin
                        state_q <= ST_HTAR1;
                    end
                    ST_HTAR1: begin
                        lad_oe_q  <= 1'b1;
                        lad_out_q <= LAD_SYNC;
                        state_q   <= ST_SYNC;
                    end
                    ST_SYNC: begin
                        // Offset 0 holds the read-only hardware version.
                        if (addr_q[4:0] != 5'd0) begin
                            bank_q[addr_q[4:0]] <= data_q;
                        end
                        wr_stb_q  <= 1'b1;
                        wr_addr_q <= addr_q[4:0];
                        wr_data_q <= data_q;
                        lad_out_q <= LAD_IDLE;
                        state_q   <= ST_TTAR;
                    end
                    ST_TTAR: begin
                        lad_oe_q  <= 1'b0;
                        lad_out_q <= LAD_IDLE;
                        state_q   <= ST_IDLE;
                    end
                    default: begin
                        lad_oe_q  <= 1'b0;
                        lad_out_q <= LAD_IDLE;
                        state_q   <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign LadOut   = lad_out_q;
    assign LadOe    = lad_oe_q;
    assign DataReg  = bank_q;
    assign WrStrobe = wr_stb_q;
    assign WrAddr   = {3'b000, wr_addr_q};
    assign WrData   = wr_data_q;

endmodule

// File: tb/tb_lpc_io_write_target.sv
// Randomised bench for lpc_io_write_target: transaction-level model predicting
// per-edge bus drive, strobes and register bank contents.
module tb_lpc_io_write_target;

    localparam logic [15:0] BASE = 16'h0800;
    localparam logic [7:0]  HWV  = 8'h01;
    localparam int          NE   = 8192;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             frame_n = 1'b1;
    logic [3:0]       lad_in = 4'hF;
    logic [3:0]       lad_out;
    logic             lad_oe;
    logic [31:0][7:0] data_reg;
    logic             wr_stb;
    logic [7:0]       wr_addr;
    logic [7:0]       wr_data;

    lpc_io_write_target dut (
        .LpcClock   (clk),
        .PciReset   (rst_n),
        .LpcFrame_n (frame_n),
        .LadIn      (lad_in),
        .LadOut     (lad_out),
        .LadOe      (lad_oe),
        .DataReg    (data_reg),
        .WrStrobe   (wr_stb),
        .WrAddr     (wr_addr),
        .WrData     (wr_data)
    );

    always #15 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    int oe_cycles = 0;
    int stb_cnt = 0;

    // Expected outputs after each edge, indexed by edge number.
    logic       exp_oe  [0:NE-1];
    logic [3:0] exp_out [0:NE-1];
    logic       exp_stb [0:NE-1];
    logic       cm_v    [0:NE-1];
    logic [4:0] cm_off  [0:NE-1];
    logic [7:0] cm_dat  [0:NE-1];

    logic [31:0][7:0] m_bank;
    logic [4:0]       m_wa = 5'd0;
    logic [7:0]       m_wd = 8'h00;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic logic [31:0][7:0] reset_bank();
        logic [31:0][7:0] b;
        for (int i = 0; i < 32; i++) b[i] = (i == 0) ? HWV : 8'h00;
        return b;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_exp(input int from, input int cnt);
        for (int e = from; e < from + cnt && e < NE; e++) begin
            exp_oe[e] = 1'b0; exp_out[e] = 4'hF; exp_stb[e] = 1'b0; cm_v[e] = 1'b0;
            cm_off[e] = 5'd0; cm_dat[e] = 8'h00;
        end
    endtask

    // Per-cycle compare of DUT outputs against the model.
    always @(negedge clk) begin : cmp
        int e;
        e = (edge_cnt < NE) ? edge_cnt : NE - 1;
        if (!rst_n) begin
            m_bank = reset_bank(); m_wa = 5'd0; m_wd = 8'h00;
        end else if (cm_v[e]) begin
            if (cm_off[e] != 5'd0) m_bank[cm_off[e]] = cm_dat[e];
            m_wa = cm_off[e];
            m_wd = cm_dat[e];
        end
        if (lad_oe === 1'b1) oe_cycles++;
        if (wr_stb === 1'b1) stb_cnt++;
        chk("LadOe", lad_oe, exp_oe[e]);
        chk("LadOut", lad_out, exp_out[e]);
        chk("WrStrobe", wr_stb, exp_stb[e]);
        chk("WrAddr", wr_addr, {3'b000, m_wa});
        chk("WrData", wr_data, m_wd);
        chk("DataReg", data_reg, m_bank);
    end

    task automatic drive(input logic f, input logic [3:0] l);
        frame_n = f;
        lad_in  = l;
        @(posedge clk);
        #1;
    endtask

    // One host cycle: START (slen clocks), CYCTYPE, 4 addr, 2 data, 4 trailing clocks.
    // abort_k / rst_k: edge offset from the last START edge at which LFRAME# abort or reset hits.
    task automatic txn(input logic [3:0] ct, input logic [15:0] addr, input logic [7:0] dat,
                       input int slen, input int abort_k, input int rst_k);
        logic [3:0] nib [1:11];
        int n;
        int ak;
        bit hit;
        nib[1] = ct;
        nib[2] = addr[15:12]; nib[3] = addr[11:8]; nib[4] = addr[7:4]; nib[5] = addr[3:0];
        nib[6] = dat[3:0];    nib[7] = dat[7:4];
        for (int k = 8; k <= 11; k++) nib[k] = 4'hF;
        for (int i = 0; i < slen; i++) drive(1'b0, 4'h0);
        n   = edge_cnt;
        ak  = (abort_k == 0) ? 99 : abort_k;
        hit = (ct == 4'b0010) && ((int'(addr) / 32) == (int'(BASE) / 32));
        if (hit && (n + 10 < NE)) begin
            if (9 < ak) begin
                exp_oe[n+9] = 1'b1; exp_out[n+9] = 4'h0;
            end
            if (10 < ak) begin
                exp_oe[n+10] = 1'b1; exp_out[n+10] = 4'hF; exp_stb[n+10] = 1'b1;
                cm_v[n+10] = 1'b1; cm_off[n+10] = 5'(int'(addr) % 32); cm_dat[n+10] = dat;
            end
        end
        for (int k = 1; k <= 11; k++) begin
            if (k == abort_k) begin
                drive(1'b0, 4'($urandom_range(1, 15)));
                drive(1'b1, 4'hF);
                return;
            end
            drive(1'b1, nib[k]);
            if (k == rst_k) begin
                chk("rst_oe_before", lad_oe, 1'b1);
                rst_n = 1'b0;
                clear_exp(edge_cnt, 24);
                #1;
                chk("rst_oe_now", lad_oe, 1'b0);
                chk("rst_out_now", lad_out, 4'hF);
                chk("rst_bank_now", data_reg, {{31{8'h00}}, 8'h01});
                repeat (2) @(posedge clk);
                #1;
                rst_n = 1'b1;
                return;
            end
        end
    endtask

    task automatic idle(input int cnt);
        for (int i = 0; i < cnt; i++) drive(1'b1, 4'($urandom_range(0, 15)));
    endtask

    initial begin
        logic [3:0]  ct;
        logic [15:0] ad;
        int          r;
        clear_exp(0, NE);
        m_bank = reset_bank();
        rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_oe", lad_oe, 1'b0);
        chk("reset_out", lad_out, 4'hF);
        chk("reset_bank", data_reg, {{31{8'h00}}, 8'h01});
        rst_n = 1'b1;
        idle(2);

        oe_cycles = 0; stb_cnt = 0;
        txn(4'b0010, 16'h080E, 8'hA5, 1, 0, 0);
        chk("d1_reg14", data_reg[14], 8'hA5);
        chk("d1_model14", m_bank[14], 8'hA5);
        chk("d1_wraddr", wr_addr, 8'h0E);
        chk("d1_wrdata", wr_data, 8'hA5);
        chk("d1_oe_cycles", oe_cycles, 2);
        chk("d1_strobes", stb_cnt, 1);
        idle(1);

        oe_cycles = 0; stb_cnt = 0;
        txn(4'b0010, 16'h0800, 8'h5A, 1, 0, 0);
        chk("d2_reg0", data_reg[0], 8'h01);
        chk("d2_wraddr", wr_addr, 8'h00);
        chk("d2_wrdata", wr_data, 8'h5A);
        chk("d2_oe_cycles", oe_cycles, 2);
        chk("d2_strobes", stb_cnt, 1);
        idle(1);

        oe_cycles = 0; stb_cnt = 0;
        txn(4'b0010, 16'h0900, 8'h77, 1, 0, 0);
        idle(1);
        txn(4'b0000, 16'h0801, 8'h66, 1, 0, 0);
        chk("d3_oe_cycles", oe_cycles, 0);
        chk("d3_strobes", stb_cnt, 0);
        chk("d3_reg1", data_reg[1], 8'h00);
        chk("d3_reg14", data_reg[14], 8'hA5);
        idle(1);

        txn(4'b0010, 16'h081F, 8'h3C, 3, 0, 0);
        chk("d4_reg31", data_reg[31], 8'h3C);
        chk("d4_wraddr", wr_addr, 8'h1F);
        idle(1);

        stb_cnt = 0;
        txn(4'b0010, 16'h0801, 8'h99, 1, 6, 0);
        chk("d5_abort_reg1", data_reg[1], 8'h00);
        chk("d5_abort_strobes", stb_cnt, 0);
        txn(4'b0010, 16'h0801, 8'h11, 1, 0, 0);
        chk("d5_reg1", data_reg[1], 8'h11);
        idle(1);

        txn(4'b0010, 16'h0805, 8'h42, 1, 0, 9);
        idle(2);
        chk("d6_bank", data_reg, {{31{8'h00}}, 8'h01});

        for (int t = 0; t < 200; t++) begin
            r  = $urandom_range(0, 9);
            ct = (r < 7) ? 4'b0010 : (r == 7) ? 4'b0000 : 4'($urandom_range(0, 15));
            ad = ($urandom_range(0, 9) < 7) ? (BASE | 16'($urandom_range(0, 31))) : 16'($urandom);
            txn(ct, ad, 8'($urandom), $urandom_range(1, 3),
                ($urandom_range(0, 99) < 15) ? $urandom_range(1, 10) : 0, 0);
            idle($urandom_range(0, 2));
        end
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
